// File: rtl/seq_div_pkg.sv
// Shared types for the seq_div signed sequential divider.
// Holds the FSM state encoding and the default operand width.
package seq_div_pkg;

    localparam int WORD_LEN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_abs.sv
// Signed-to-magnitude helper: WORD_LEN+1-bit magnitude plus sign bit.
// The extra bit keeps |most-negative| representable without wrap.
module div_abs
    import seq_div_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
) (
    input  logic [WORD_LEN-1:0] val,
    output logic [WORD_LEN:0]   mag,
    output logic                neg
);

    logic [WORD_LEN:0] ext;

    assign neg = val[WORD_LEN-1];
    assign ext = {val[WORD_LEN-1], val};
    assign mag = neg ? -ext : ext;

endmodule

// File: rtl/seq_div.sv
// Signed restoring radix-2 divider, one quotient bit per cycle, truncating.
// Define SEQ_DIV_ZERO_DET_EN for the early-exit zero-divisor path.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
) (
    input  logic                i_clk,
    input  logic                i_arst,
    input  logic                i_start,
    input  logic [WORD_LEN-1:0] i_dividend,
    input  logic [WORD_LEN-1:0] i_divisor,
    output logic                o_busy,
    output logic                o_done,
    output logic [WORD_LEN-1:0] o_quotient,
    output logic [WORD_LEN-1:0] o_remainder,
    output logic                o_div_by_zero
);

    localparam int CW = $clog2(WORD_LEN);

    state_t              state;
    state_t              state_nxt;
    logic [WORD_LEN:0]   dvd_mag;
    logic [WORD_LEN:0]   dvs_mag;
    logic [WORD_LEN:0]   dvs_r;
    logic [WORD_LEN:0]   prem;
    logic [WORD_LEN:0]   trial;
    logic [WORD_LEN-1:0] dvd_r;
    logic [WORD_LEN-1:0] quo;
    logic [CW-1:0]       cnt;
    logic                dvd_neg;
    logic                dvs_neg;
    logic                sgn_n;
    logic                sgn_d;
    logic                last;
    logic                fit;
    logic                capture;
    logic                unused_bits;

    div_abs #(.WORD_LEN(WORD_LEN)) u_abs_dvd (
        .val (i_dividend),
        .mag (dvd_mag),
        .neg (dvd_neg)
    );

    div_abs #(.WORD_LEN(WORD_LEN)) u_abs_dvs (
        .val (i_divisor),
        .mag (dvs_mag),
        .neg (dvs_neg)
    );

    // Top bits are provably zero: magnitudes <= 2^(W-1), remainders < divisor.
    assign unused_bits = dvd_mag[WORD_LEN] ^ prem[WORD_LEN];

    assign last    = cnt == CW'(WORD_LEN - 1);
    assign capture = (state == IDLE) && i_start;
    assign trial   = {prem[WORD_LEN-1:0], dvd_r[WORD_LEN-1]};
    assign fit     = trial >= dvs_r;
    assign o_busy  = state != IDLE;
    assign o_done  = state == DONE;

`ifdef SEQ_DIV_ZERO_DET_EN
    logic dvs_zero;
    assign dvs_zero = i_divisor == '0;
`else
    assign o_div_by_zero = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_start) begin
`ifdef SEQ_DIV_ZERO_DET_EN
                    state_nxt = dvs_zero ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC:    if (last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            dvd_r         <= '0;
            dvs_r         <= '0;
            prem          <= '0;
            quo           <= '0;
            cnt           <= '0;
            sgn_n         <= 1'b0;
            sgn_d         <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
`ifdef SEQ_DIV_ZERO_DET_EN
            o_div_by_zero <= 1'b0;
`endif
        end else if (capture) begin
            dvd_r <= dvd_mag[WORD_LEN-1:0];
            dvs_r <= dvs_mag;
            sgn_n <= dvd_neg;
            sgn_d <= dvs_neg;
            cnt   <= '0;
            prem  <= '0;
            quo   <= '0;
`ifdef SEQ_DIV_ZERO_DET_EN
            if (dvs_zero) begin
                o_quotient    <= '1;
                o_remainder   <= i_dividend;
                o_div_by_zero <= 1'b1;
            end
`endif
        end else if (state == CALC) begin
            cnt   <= cnt + CW'(1);
            dvd_r <= {dvd_r[WORD_LEN-2:0], 1'b0};
            prem  <= fit ? trial - dvs_r : trial;
            quo   <= {quo[WORD_LEN-2:0], fit};
        end else if (state == FIX) begin
            o_quotient  <= (sgn_n ^ sgn_d) ? -quo : quo;
            o_remainder <= sgn_n ? -prem[WORD_LEN-1:0]
                                 : prem[WORD_LEN-1:0];
`ifdef SEQ_DIV_ZERO_DET_EN
            o_div_by_zero <= 1'b0;
`endif
        end
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 8, giving the operand width in bits (even, >= 4).
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_arst, input, 1, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port i_start, input, 1, a request to begin a division; sampled only when o_busy is low.
REQ-005 The block SHALL have port i_dividend, input, WORD_LEN, a signed dividend captured with i_start.
REQ-006 The block SHALL have port i_divisor, input, WORD_LEN, a signed divisor captured with i_start.
REQ-007 The block SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-008 The block SHALL have port o_done, output, 1, a one-cycle pulse marking valid results.
REQ-009 The block SHALL have port o_quotient, output, WORD_LEN, the signed quotient.
REQ-010 The block SHALL have port o_remainder, output, WORD_LEN, the signed remainder.
REQ-011 The block SHALL have port o_div_by_zero, output, 1, flagging that the divisor was zero; valid with o_done.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-013 FSM transitions SHALL be: IDLE->CALC on i_start; CALC->FIX after exactly WORD_LEN iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 Capture SHALL store the operand magnitudes and both operand signs, and SHALL clear the iteration counter and partial remainder.
REQ-015 CALC SHALL run a restoring radix-2 algorithm, one quotient bit per cycle, MSB first, using a WORD_LEN+1-bit partial remainder.
REQ-016 FIX SHALL negate the quotient if the operand signs differ, and SHALL give the remainder the sign of the dividend.
REQ-017 Division SHALL truncate toward zero, so that dividend == quotient*divisor + remainder and |remainder| < |divisor|.
REQ-018 o_done SHALL pulse high during DONE only, i.e. WORD_LEN+2 cycles after the cycle in which i_start was accepted.
REQ-019 The minimum start-to-start interval SHALL be WORD_LEN+3 cycles.
REQ-020 o_quotient, o_remainder and o_div_by_zero SHALL be registered, update on entry to DONE, and hold until the next DONE.
REQ-021 i_start SHALL be ignored while o_busy is high, including during DONE; operand changes mid-operation SHALL have no effect.
REQ-022 The overflow case most-negative / -1 SHALL give quotient = most-negative (two's-complement wrap), remainder 0 and o_div_by_zero 0.
REQ-023 Arithmetic on the most-negative operand SHALL use WORD_LEN+1-bit magnitudes so that no intermediate value overflows.

Reset
REQ-024 While i_arst is high the FSM SHALL be in IDLE, and o_busy, o_done, o_quotient, o_remainder, o_div_by_zero and all internal registers SHALL be 0.
REQ-025 Assertion of reset mid-operation SHALL abort the operation without producing o_done.
REQ-026 After reset deasserts, the first i_start SHALL be accepted on the first rising edge.

Configuration
REQ-027 With macro SEQ_DIV_ZERO_DET_EN defined, a zero divisor at capture SHALL go IDLE->DONE directly (o_done 1 cycle after start) with o_div_by_zero=1, o_quotient all-ones and o_remainder = dividend.
REQ-028 Without SEQ_DIV_ZERO_DET_EN, a zero divisor SHALL take normal latency with unspecified o_quotient/o_remainder, o_div_by_zero SHALL be tied 0, and no zero-compare logic SHALL exist.

Structure
REQ-029 Package seq_div_pkg SHALL hold the FSM state enum typedef and the default WORD_LEN constant.
REQ-030 One combinational sub-module, div_abs, SHALL return a WORD_LEN+1-bit magnitude and a sign bit from a WORD_LEN-bit signed value, instantiated twice.
REQ-031 No other hierarchy SHALL be used.

Verification (WORD_LEN=8)
REQ-032 The bench SHALL cover: 100 / 7 -> q=14, r=2, o_done exactly 10 cycles after start.
REQ-033 The bench SHALL cover: -100/7 -> q=-14, r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2.
REQ-034 The bench SHALL cover: -128 / -1 -> q=-128, r=0, o_div_by_zero=0; -128/1 -> q=-128, r=0.
REQ-035 The bench SHALL cover: 5 / 0 with SEQ_DIV_ZERO_DET_EN -> o_div_by_zero=1, q=8'hFF, r=5, o_done one cycle after start.
REQ-036 The bench SHALL cover: a second i_start with new operands 3 cycles after the first -> ignored; results match the first operands; next start accepted after DONE.
REQ-037 The bench SHALL cover: i_arst pulsed during CALC -> all outputs 0 and no o_done; then 1000 random operand pairs (nonzero divisor) checked against the reference model via REQ-017.
